// File: rtl/wall_drawer.sv
`default_nettype none
// ============================================================================
//  Module   : wall_drawer
//  Purpose  : Redraws the game wall on a start pulse. When an earlier wall is
//             on screen it is first erased with the background colour, then
//             the new wall is drawn with its hole. One pixel write per cycle
//             goes out to the VGA adapter, and done pulses once at the end.
//  Options  : WALL_HOLE_CLAMP_EN - when defined, the latched hole top is
//             clamped so that the whole gap stays inside the wall height.
//  Revision : 1.0 - initial release
// ============================================================================
module wall_drawer #(
    parameter int         WALL_WIDTH  = 4,
    parameter int         WALL_HEIGHT = 120,
    parameter int         HOLE_HEIGHT = 50,
    parameter int         SCREEN_W    = 160,
    parameter logic [2:0] WALL_COLOUR = 3'b010,
    parameter logic [2:0] BG_COLOUR   = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] wall_x,
    input  logic [7:0] hole_y,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int ROW_W = (WALL_HEIGHT > 1) ? $clog2(WALL_HEIGHT) : 1;
    localparam int COL_W = (WALL_WIDTH  > 1) ? $clog2(WALL_WIDTH)  : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ERASE = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [7:0]       cur_x_q, cur_x_d;
    logic [7:0]       cur_hole_q, cur_hole_d;
    // The erase pass paints the whole old rectangle in background colour, so
    // the old hole position is never needed and only the old x is kept.
    logic [7:0]       prev_x_q, prev_x_d;
    logic             prev_valid_q, prev_valid_d;

    logic [7:0]       x_q, y_q;
    logic [2:0]       colour_q;
    logic             plot_q, busy_q, done_q;

    logic             w_emit, w_draw, w_done;
    logic [7:0]       w_base, w_hole, w_hole_in;
    logic             w_last;
    logic [ROW_W-1:0] w_row_adv;
    logic [COL_W-1:0] w_col_adv;
    logic [8:0]       w_px9, w_row9, w_hole9;
    logic             w_on_screen, w_in_hole;

`ifdef WALL_HOLE_CLAMP_EN
    assign w_hole_in = (hole_y > 8'(WALL_HEIGHT - HOLE_HEIGHT))
                     ? 8'(WALL_HEIGHT - HOLE_HEIGHT) : hole_y;
`else
    assign w_hole_in = hole_y;
`endif

    // Scan position bookkeeping: column fastest, then row.
    assign w_last    = (col_q == COL_W'(WALL_WIDTH - 1)) && (row_q == ROW_W'(WALL_HEIGHT - 1));
    assign w_col_adv = (col_q == COL_W'(WALL_WIDTH - 1)) ? '0 : col_q + 1'b1;
    assign w_row_adv = (col_q == COL_W'(WALL_WIDTH - 1)) ? row_q + 1'b1 : row_q;

    // Pixel arithmetic is done on the coordinates about to be registered,
    // 9 bits wide so neither the x sum nor the hole bound can wrap.
    assign w_px9       = {1'b0, w_base} + 9'(col_d);
    assign w_on_screen = (w_px9 < 9'(SCREEN_W));
    assign w_row9      = 9'(row_d);
    assign w_hole9     = {1'b0, w_hole};
    assign w_in_hole   = (w_row9 >= w_hole9) && (w_row9 < (w_hole9 + 9'(HOLE_HEIGHT)));

    // Next-state logic: picks the next pixel to emit and the phase it belongs to.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        cur_x_d      = cur_x_q;
        cur_hole_d   = cur_hole_q;
        prev_x_d     = prev_x_q;
        prev_valid_d = prev_valid_q;
        w_emit       = 1'b0;
        w_draw       = 1'b0;
        w_done       = 1'b0;
        w_base       = cur_x_q;
        w_hole       = cur_hole_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_x_d    = wall_x;
                    cur_hole_d = w_hole_in;
                    row_d      = '0;
                    col_d      = '0;
                    w_emit     = 1'b1;
                    if (prev_valid_q) begin
                        state_d = S_ERASE;
                        w_base  = prev_x_q;
                    end else begin
                        state_d = S_DRAW;
                        w_draw  = 1'b1;
                        w_base  = wall_x;
                        w_hole  = w_hole_in;
                    end
                end
            end
            S_ERASE: begin
                w_emit = 1'b1;
                if (w_last) begin
                    // First draw pixel follows the last erase pixel directly.
                    state_d = S_DRAW;
                    row_d   = '0;
                    col_d   = '0;
                    w_draw  = 1'b1;
                end else begin
                    row_d  = w_row_adv;
                    col_d  = w_col_adv;
                    w_base = prev_x_q;
                end
            end
            S_DRAW: begin
                if (w_last) begin
                    state_d      = S_DONE;
                    w_done       = 1'b1;
                    prev_x_d     = cur_x_q;
                    prev_valid_d = 1'b1;
                end else begin
                    w_emit = 1'b1;
                    w_draw = 1'b1;
                    row_d  = w_row_adv;
                    col_d  = w_col_adv;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered pixel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            cur_x_q      <= 8'd0;
            cur_hole_q   <= 8'd0;
            prev_x_q     <= 8'd0;
            prev_valid_q <= 1'b0;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            colour_q     <= BG_COLOUR;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            cur_x_q      <= cur_x_d;
            cur_hole_q   <= cur_hole_d;
            prev_x_q     <= prev_x_d;
            prev_valid_q <= prev_valid_d;
            plot_q       <= w_emit && w_on_screen;
            busy_q       <= (state_d != S_IDLE);
            done_q       <= w_done;
            if (w_emit) begin
                x_q      <= w_px9[7:0];
                y_q      <= 8'(row_d);
                colour_q <= (w_draw && !w_in_hole) ? WALL_COLOUR : BG_COLOUR;
            end
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_wall_drawer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wall_drawer
//  Purpose  : Scoreboard bench for wall_drawer. Each redraw request pushes
//             the expected plotted pixels into a queue; a monitor pops and
//             compares on every plot strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wall_drawer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] wall_x, hole_y;
    logic [7:0] x, y;
    logic [2:0] colour;
    logic       plot, busy, done;

    typedef struct packed {
        logic [7:0] px;
        logic [7:0] py;
        logic [2:0] pc;
    } pix_t;

    pix_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    bit       m_prev_valid = 1'b0;
    int       m_prev_x     = 0;

    wall_drawer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .wall_x (wall_x),
        .hole_y (hole_y),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Monitor: every plot strobe must match the oldest expected pixel.
    always @(negedge clk) begin
        if (plot === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL pixel_unexpected: got x=%0d y=%0d c=%0d expected none", x, y, colour);
            end else begin
                pix_t e;
                e = sb.pop_front();
                chk("pixel", {13'd0, x, y, colour}, {13'd0, e.px, e.py, e.pc});
            end
        end
    end

    // Reference: rectangle scan with clipping and hole rule, plain arithmetic.
    task automatic model_push(input int wx, input int hy);
        int he;
        if (m_prev_valid) begin
            for (int r = 0; r < 120; r++)
                for (int c = 0; c < 4; c++)
                    if (m_prev_x + c < 160) sb.push_back({8'(m_prev_x + c), 8'(r), 3'b000});
        end
        he = hy;
`ifdef WALL_HOLE_CLAMP_EN
        if (he > 70) he = 70;
`endif
        for (int r = 0; r < 120; r++)
            for (int c = 0; c < 4; c++)
                if (wx + c < 160)
                    sb.push_back({8'(wx + c), 8'(r), ((r >= he) && (r < he + 50)) ? 3'b000 : 3'b010});
    endtask

    task automatic run_draw(input int wx, input int hy, input int glitch_at, input int reset_at);
        int  exp_cycles;
        int  n;
        bit  got;
        exp_cycles = (m_prev_valid ? 960 : 480) + 1;
        model_push(wx, hy);
        @(posedge clk); #1;
        wall_x = 8'(wx); hole_y = 8'(hy); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; wall_x = 8'($urandom); hole_y = 8'($urandom);
        n = 0; got = 1'b0;
        while (!got && n < 3000) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy_rise", {31'd0, busy}, 32'd1);
            if (n == glitch_at) begin
                start = 1'b1; wall_x = 8'($urandom); hole_y = 8'($urandom);
            end
            if (n == glitch_at + 1) start = 1'b0;
            if (n == reset_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                chk("abort_plot", {31'd0, plot}, 32'd0);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_done", {31'd0, done}, 32'd0);
                sb.delete();
                m_prev_valid = 1'b0;
                return;
            end
            if (done === 1'b1) got = 1'b1;
        end
        chk("done_cycle", n, exp_cycles);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("busy_fall", {31'd0, busy}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);
        sb.delete();
        m_prev_valid = 1'b1;
        m_prev_x     = wx;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; wall_x = 8'd0; hole_y = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_x", {24'd0, x}, 32'd0);
        chk("rst_y", {24'd0, y}, 32'd0);
        chk("rst_colour", {29'd0, colour}, 32'd0);
        chk("rst_plot", {31'd0, plot}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_draw(100, 20, -1, -1);                 // first draw, no erase
        run_draw(88, 40, -1, -1);                  // erase then draw
        run_draw(158, int'($urandom_range(0, 255)), -1, -1); // right-edge clip
        run_draw(30, 60, 490, -1);                 // start pulse 10 cycles into DRAW
        run_draw(50, 10, -1, 200);                 // reset at erase pixel 200
        run_draw(70, 100, -1, -1);                 // after abort: no erase, hole 100
        for (int i = 0; i < 5; i++)
            run_draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), -1, -1);

        // Start coinciding with reset: reset wins, nothing starts.
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b1; wall_x = 8'd10; hole_y = 8'd10;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        chk("rst_start_plot", {31'd0, plot}, 32'd0);
        m_prev_valid = 1'b0;
        run_draw(120, 0, -1, -1);                  // skips erase after reset

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
